// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-number constants and word types for the MIPS datapath
package mips_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_GP   = 5'd28;
    localparam reg_addr_t REG_SP   = 5'd29;
    localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/writeback_reg_file_if.sv
// rtl/writeback_reg_file_if.sv - write-back commit port, operand read ports and debug port of the register file
interface writeback_reg_file_if;
    import mips_pkg::*;

    logic      RegWrite;
    reg_addr_t WriteReg;
    word_t     WriteData;
    reg_addr_t ReadReg1;
    reg_addr_t ReadReg2;
    word_t     ReadData1;
    word_t     ReadData2;
    reg_addr_t DbgReg;
    word_t     DbgData;
    word_t     WriteCount;

    modport master (
        output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DbgReg,
        input  ReadData1, ReadData2, DbgData, WriteCount
    );

    modport slave (
        input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DbgReg,
        output ReadData1, ReadData2, DbgData, WriteCount
    );

endinterface

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port: register select, $zero forcing, optional write bypass
module regfile_read_port
    import mips_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  word_t [31:1] regs_i,
    input  reg_addr_t    addr_i,
    input  logic         wr_en_i,
    input  reg_addr_t    wr_addr_i,
    input  word_t        wr_data_i,
    output word_t        data_o
);

    word_t stored;
    logic  bypass_hit;

    // A mux rather than regs_i[addr_i] keeps index 0 from ever reaching the array.
    always_comb begin
        stored = '0;
        for (int i = 1; i < 32; i++) begin
            if (addr_i == reg_addr_t'(i)) begin
                stored = regs_i[i];
            end
        end
    end

    assign bypass_hit = BYPASS && wr_en_i && (wr_addr_i == addr_i);

    always_comb begin
        data_o = stored;
        if (addr_i == REG_ZERO) begin
            data_o = '0;
        end else if (bypass_hit) begin
            data_o = wr_data_i;
        end
    end

endmodule

// File: rtl/writeback_reg_file.sv
// rtl/writeback_reg_file.sv - 31x32 architectural register file committing the write-back stage result
module writeback_reg_file
    import mips_pkg::*;
#(
    parameter word_t SP_INIT = 32'h0000_3FFC,
    parameter word_t GP_INIT = 32'h0000_1800,
    parameter bit    BYPASS  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    writeback_reg_file_if.slave  bus
);

    word_t [31:1] regs_q;
    word_t [31:1] regs_d;
    word_t        write_count_q;
    word_t        write_count_d;
    logic         commit;

    assign commit = bus.RegWrite && (bus.WriteReg != REG_ZERO);

    always_comb begin
        regs_d        = regs_q;
        write_count_d = write_count_q;
        if (commit) begin
            regs_d[bus.WriteReg] = bus.WriteData;
            write_count_d        = write_count_q + 32'd1;
        end
    end

    // Reset wins over a write presented on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q         <= '0;
            regs_q[REG_GP] <= GP_INIT;
            regs_q[REG_SP] <= SP_INIT;
            write_count_q  <= '0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    assign bus.WriteCount = write_count_q;

    regfile_read_port #(.BYPASS(BYPASS)) u_rd1 (
        .regs_i    (regs_q),
        .addr_i    (bus.ReadReg1),
        .wr_en_i   (bus.RegWrite),
        .wr_addr_i (bus.WriteReg),
        .wr_data_i (bus.WriteData),
        .data_o    (bus.ReadData1)
    );

    regfile_read_port #(.BYPASS(BYPASS)) u_rd2 (
        .regs_i    (regs_q),
        .addr_i    (bus.ReadReg2),
        .wr_en_i   (bus.RegWrite),
        .wr_addr_i (bus.WriteReg),
        .wr_data_i (bus.WriteData),
        .data_o    (bus.ReadData2)
    );

    regfile_read_port #(.BYPASS(1'b0)) u_dbg (
        .regs_i    (regs_q),
        .addr_i    (bus.DbgReg),
        .wr_en_i   (bus.RegWrite),
        .wr_addr_i (bus.WriteReg),
        .wr_data_i (bus.WriteData),
        .data_o    (bus.DbgData)
    );

endmodule

// File: tb/tb_writeback_reg_file.sv
// tb/tb_writeback_reg_file.sv - bench for writeback_reg_file with bypassing and non-bypassing instances
module tb_writeback_reg_file;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic we;
    logic [4:0]  wr, r1, r2, dbg;
    logic [31:0] wd;

    always #5 clk = ~clk;

    writeback_reg_file_if a_if ();
    writeback_reg_file_if b_if ();

    assign a_if.RegWrite = we;  assign b_if.RegWrite = we;
    assign a_if.WriteReg = wr;  assign b_if.WriteReg = wr;
    assign a_if.WriteData = wd; assign b_if.WriteData = wd;
    assign a_if.ReadReg1 = r1;  assign b_if.ReadReg1 = r1;
    assign a_if.ReadReg2 = r2;  assign b_if.ReadReg2 = r2;
    assign a_if.DbgReg = dbg;   assign b_if.DbgReg = dbg;

    writeback_reg_file #(.BYPASS(1'b1)) dut_a (.clk(clk), .reset(rst), .bus(a_if.slave));
    writeback_reg_file #(.BYPASS(1'b0)) dut_b (.clk(clk), .reset(rst), .bus(b_if.slave));

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && we && wr == a) return wd;
        return m_regs[a];
    endfunction

    task automatic m_edge();
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 32'd0;
            m_regs[28] = 32'h0000_1800;
            m_regs[29] = 32'h0000_3FFC;
            m_cnt = 32'd0;
        end else if (we && wr != 5'd0) begin
            m_regs[wr] = wd;
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("a_rd1", a_if.ReadData1, m_read(r1, 1'b1));
        chk("a_rd2", a_if.ReadData2, m_read(r2, 1'b1));
        chk("a_dbg", a_if.DbgData, m_read(dbg, 1'b0));
        chk("a_cnt", a_if.WriteCount, m_cnt);
        chk("b_rd1", b_if.ReadData1, m_read(r1, 1'b0));
        chk("b_rd2", b_if.ReadData2, m_read(r2, 1'b0));
        chk("b_dbg", b_if.DbgData, m_read(dbg, 1'b0));
        chk("b_cnt", b_if.WriteCount, m_cnt);
    endtask

    // Inputs are set just after a rising edge; outputs are sampled at the falling edge.
    task automatic cycle(input bit do_chk);
        @(negedge clk);
        if (do_chk) chk_model();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic [4:0] w, input logic [31:0] d,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        rst = r; we = e; wr = w; wd = d; r1 = a1; r2 = a2; dbg = ad;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1, r2, dbg;
        logic [31:0] e1, e2, edbg, ecnt;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd28, 5'd29, 32'h0,         32'h1800,      32'h3FFC,      32'd0};
        tbl[1] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd29, 5'd28, 32'h0,         32'h3FFC,      32'h1800,      32'd0};
        tbl[2] = '{1'b1, 5'd8,  32'hDEADBEEF,  5'd8,  5'd8,  5'd8,  32'hDEADBEEF,  32'hDEADBEEF,  32'h0,         32'd0};
        tbl[3] = '{1'b0, 5'd0,  32'h0,         5'd8,  5'd0,  5'd8,  32'hDEADBEEF,  32'h0,         32'hDEADBEEF,  32'd1};
        tbl[4] = '{1'b1, 5'd0,  32'hFFFFFFFF,  5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'd1};
        tbl[5] = '{1'b0, 5'd0,  32'h0,         5'd8,  5'd0,  5'd0,  32'hDEADBEEF,  32'h0,         32'h0,         32'd1};
        tbl[6] = '{1'b1, 5'd5,  32'h12345678,  5'd5,  5'd5,  5'd5,  32'h12345678,  32'h12345678,  32'h0,         32'd1};
        tbl[7] = '{1'b1, 5'd5,  32'hCAFEF00D,  5'd5,  5'd5,  5'd5,  32'hCAFEF00D,  32'hCAFEF00D,  32'h12345678,  32'd2};
        tbl[8] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd8,  5'd5,  32'hCAFEF00D,  32'hDEADBEEF,  32'hCAFEF00D,  32'd3};
        tbl[9] = '{1'b0, 5'd8,  32'h0,         5'd8,  5'd29, 5'd8,  32'hDEADBEEF,  32'h3FFC,      32'hDEADBEEF,  32'd3};

        foreach (m_regs[i]) m_regs[i] = 32'd0;
        m_cnt = 32'd0;

        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        #1;
        cycle(1'b0);

        for (int i = 0; i < 10; i++) begin
            drive(1'b0, tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].r1, tbl[i].r2, tbl[i].dbg);
            @(negedge clk);
            chk("tbl_rd1", a_if.ReadData1, tbl[i].e1);
            chk("tbl_rd2", a_if.ReadData2, tbl[i].e2);
            chk("tbl_dbg", a_if.DbgData, tbl[i].edbg);
            chk("tbl_cnt", a_if.WriteCount, tbl[i].ecnt);
            chk_model();
            @(posedge clk);
            m_edge();
            #1;
        end

        // Reset colliding with a write to $sp: the write must be lost.
        drive(1'b1, 1'b1, 5'd29, 32'h0000_AAAA, 5'd29, 5'd8, 5'd29);
        cycle(1'b0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd29, 5'd8, 5'd29);
        @(negedge clk);
        chk("rst_sp", a_if.ReadData1, 32'h0000_3FFC);
        chk("rst_r8", a_if.ReadData2, 32'h0);
        chk("rst_cnt", a_if.WriteCount, 32'h0);
        @(posedge clk); m_edge(); #1;

        // Counter wrap: preload the count, then one valid write must roll it to 0.
        @(negedge clk);
        force dut_a.write_count_q = 32'hFFFF_FFFF;
        force dut_b.write_count_q = 32'hFFFF_FFFF;
        #1;
        release dut_a.write_count_q;
        release dut_b.write_count_q;
        m_cnt = 32'hFFFF_FFFF;
        chk("pre_wrap", a_if.WriteCount, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 5'd31, 32'h0BAD_F00D, 5'd31, 5'd0, 5'd31);
        cycle(1'b1);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd0, 5'd31);
        @(negedge clk);
        chk("wrap_cnt", a_if.WriteCount, 32'h0);
        chk("wrap_ra", a_if.DbgData, 32'h0BAD_F00D);
        @(posedge clk); m_edge(); #1;

        for (int n = 0; n < 1000; n++) begin
            logic [4:0] a1;
            a1 = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 63) == 0), 1'($urandom), 5'($urandom_range(0, 31)), $urandom,
                  a1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) wr = a1;
            if ($urandom_range(0, 7) == 0) r2 = r1;
            if ($urandom_range(0, 7) == 0) dbg = wr;
            cycle(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/writeback_reg_file.md
# writeback_reg_file

Architectural register file for the MIPS datapath: the consumer of the write-back selection stage. It takes the 32-bit write-back word chosen by the 3-input write-back mux and the 5-bit destination chosen by the destination-register mux, and commits it on the clock edge. It supplies two combinational read ports to decode/ALU operand selection, with same-cycle write-to-read bypass. A third debug read port serves the testbench.

## Interface
Parameters:
- `SP_INIT`, default 32'h0000_3FFC: reset value of register 29 ($sp).
- `GP_INIT`, default 32'h0000_1800: reset value of register 28 ($gp).
- `BYPASS`, default 1: 1 = a same-cycle write is visible on the read ports; 0 = read returns the old value.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `RegWrite`  in  1: write enable.
- `WriteReg`  in  5: destination register number.
- `WriteData`  in  32: write-back word.
- `ReadReg1`, `ReadReg2`  in  5 each: source register numbers.
- `ReadData1`, `ReadData2`  out  32 each: source operands, combinational.
- `DbgReg`  in  5: debug read address.
- `DbgData`  out  32: debug read data, combinational, never bypassed.
- `WriteCount`  out  32: number of committed writes since reset.

## Operation
- Storage: 31 registers × 32 bits, for indices 1..31. Register 0 is not stored. Any read of index 0 returns 0.
- Write: at a rising edge with `reset`=0, `RegWrite`=1 and `WriteReg`≠0, the register at `WriteReg` takes `WriteData`, and `WriteCount` increments by 1.
- A write to index 0 is discarded and does not increment `WriteCount`.
- `WriteCount` wraps from 32'hFFFF_FFFF to 0, with no saturation.
- Read ports: the output is 0 if the address is 0. Otherwise, with `BYPASS`=1, `RegWrite`=1 and `WriteReg` equal to the read address, the output is `WriteData`. Otherwise the output is the stored value.
- The bypass applies independently to each read port. Both ports may read the same register, and each read port may match `WriteReg`.
- `DbgData` always shows the stored value, with no bypass.
- Reset: at a rising edge with `reset`=1:
  - every register clears to 0, except register 28 = `GP_INIT` and register 29 = `SP_INIT`;
  - `WriteCount` goes to 0;
  - any write presented in the same cycle is dropped.
- Reset dominates `RegWrite`. Reset asserted mid-program takes effect at the next edge with no partial commit.
- All inputs are sampled only at the edge or combinationally. There are no X-propagation hazards from an unwritten register, because every register has a reset value.

## Timing
- Write latency: 1 clock. Data presented in cycle N is stored and visible on `DbgData` in cycle N+1.
- Read latency: 0 (combinational). With `BYPASS`=1, a same-cycle write has an effective read latency of 0.
- Output values after reset: `ReadData1`/`ReadData2` track the address (0, `GP_INIT`, `SP_INIT` or 0 for other registers), `DbgData` likewise, `WriteCount` = 0.
- There is no back-pressure. A write every cycle is sustained indefinitely.
- Back-to-back writes to the same register: the last write wins, and each write increments `WriteCount`.

## Structure
- Shared package `mips_pkg` holds:
  - `REG_ZERO`=0, `REG_GP`=28, `REG_SP`=29, `REG_RA`=31;
  - `reg_addr_t` (5-bit) and `word_t` (32-bit).
- One sub-module, `regfile_read_port`, is instantiated three times. It implements the zero check and optional bypass against the write port: the two operand ports are instantiated with bypass enabled and `DbgData` with bypass disabled.
- The storage array, reset logic and `WriteCount` live in the top module.

## Test plan
- Reset: hold `reset`=1 for 1 edge, then read addresses 0, 28, 29, 31 → 0, 32'h1800, 32'h3FFC, 0; `WriteCount`=0.
- Basic write/read: write 32'hDEADBEEF to register 8. On the next cycle `ReadData1`(8)=32'hDEADBEEF and `WriteCount`=1.
- Register 0 protection: `RegWrite`=1, `WriteReg`=0, `WriteData`=32'hFFFF_FFFF → `ReadData2`(0)=0; `WriteCount` is unchanged.
- Bypass: in the same cycle write 32'h1234_5678 to register 5 with `ReadReg1`=`ReadReg2`=5 → both ports show 32'h1234_5678 and `DbgData`(5) shows the old value. Repeat with `BYPASS`=0 → the ports show the old value.
- Reset vs write collision: `reset`=1 together with a write of 32'hAAAA to register 29 → after the edge register 29 = `SP_INIT` and `WriteCount`=0.
- Counter wrap and stress: force `WriteCount` to 32'hFFFF_FFFF via 2^32-1 writes, or via a force in simulation. The next valid write gives 0. Then run 1000 random writes against a reference model, checking all three ports every cycle.
